// File: rtl/bus_arbiter.sv
// bus_arbiter: XT system bus ownership arbiter between the 8088 (through 8288 status)
// and the 8237 DMA hold request. DMA is only granted in a passive, unlocked CPU window,
// and AEN#, the CPU driver enable and HLDA are sequenced so that the two masters never
// drive the bus at the same time. The CPU is held off through the ready path while DMA
// owns the bus.
module bus_arbiter #(
    parameter int HOLD_SETUP_CYCLES = 2,
    parameter int RELEASE_CYCLES    = 1,
    parameter int MIN_CPU_CYCLES    = 4,
    parameter int MAX_DMA_CYCLES    = 1024
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] processor_status,
    input  logic       processor_lock_n,
    input  logic       hold_request,
    output logic       hold_acknowledge,
    output logic       address_enable_n,
    output logic       cpu_bus_enable,
    output logic       cpu_wait_request,
    output logic       watchdog_timeout
);

    localparam int SETUP_W = $clog2(HOLD_SETUP_CYCLES + 1);
    localparam int REL_W   = $clog2(RELEASE_CYCLES + 1);
    localparam int FAIR_W  = (MIN_CPU_CYCLES > 0) ? $clog2(MIN_CPU_CYCLES + 1) : 1;
    localparam int DMA_W   = (MAX_DMA_CYCLES > 0) ? $clog2(MAX_DMA_CYCLES + 1) : 1;
    localparam bit WDOG_EN = (MAX_DMA_CYCLES > 0);

    // Terminal values: the timed states leave on the clock that sees the last count.
    localparam logic [SETUP_W-1:0] SETUP_LAST = SETUP_W'(HOLD_SETUP_CYCLES - 1);
    localparam logic [REL_W-1:0]   REL_LAST   = REL_W'(RELEASE_CYCLES - 1);
    localparam logic [FAIR_W-1:0]  FAIR_INIT  = FAIR_W'(MIN_CPU_CYCLES);
    localparam logic [DMA_W-1:0]   DMA_LAST   = WDOG_EN ? DMA_W'(MAX_DMA_CYCLES - 1) : '0;
    localparam logic [DMA_W-1:0]   DMA_SAT    = '1;

    typedef enum logic [2:0] {
        ST_CPU,
        ST_SYNC,
        ST_AEN,
        ST_DMA,
        ST_RELEASE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [2:0]         status_p1;
    logic [SETUP_W-1:0] setup_cnt;
    logic [SETUP_W-1:0] setup_nxt;
    logic [REL_W-1:0]   rel_cnt;
    logic [REL_W-1:0]   rel_nxt;
    logic [FAIR_W-1:0]  fair_cnt;
    logic [FAIR_W-1:0]  fair_nxt;
    logic [DMA_W-1:0]   dma_cnt;
    logic [DMA_W-1:0]   dma_nxt;
    logic               wd_nxt;
    logic               passive_window;
    logic               cpu_owns_nxt;

    // Two consecutive passive status samples with LOCK# released mark a safe handover point.
    assign passive_window = (processor_status == 3'b111) && (status_p1 == 3'b111) && processor_lock_n;

    // CPU and SYNC keep the CPU on the bus; every other state belongs to DMA.
    assign cpu_owns_nxt = (state_nxt == ST_CPU) || (state_nxt == ST_SYNC);

    // State, previous-status sample and phase counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_CPU;
            status_p1 <= 3'b111;
            setup_cnt <= '0;
            rel_cnt   <= '0;
            fair_cnt  <= '0;
            dma_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            status_p1 <= processor_status;
            setup_cnt <= setup_nxt;
            rel_cnt   <= rel_nxt;
            fair_cnt  <= fair_nxt;
            dma_cnt   <= dma_nxt;
        end
    end

    // Next-state and counter update; a dropped request always wins over a timer expiring.
    always_comb begin
        state_nxt = state;
        setup_nxt = setup_cnt;
        rel_nxt   = rel_cnt;
        fair_nxt  = fair_cnt;
        dma_nxt   = dma_cnt;
        wd_nxt    = 1'b0;
        case (state)
            ST_CPU: begin
                if (fair_cnt != '0) begin
                    fair_nxt = fair_cnt - 1'b1;
                end
                if (hold_request && (fair_cnt == '0)) begin
                    state_nxt = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (!hold_request) begin
                    state_nxt = ST_CPU;
                end else if (passive_window) begin
                    state_nxt = ST_AEN;
                    setup_nxt = '0;
                end
            end
            ST_AEN: begin
                if (!hold_request) begin
                    state_nxt = ST_RELEASE;
                    rel_nxt   = '0;
                end else if (setup_cnt == SETUP_LAST) begin
                    state_nxt = ST_DMA;
                    dma_nxt   = '0;
                end else begin
                    setup_nxt = setup_cnt + 1'b1;
                end
            end
            ST_DMA: begin
                if (dma_cnt != DMA_SAT) begin
                    dma_nxt = dma_cnt + 1'b1;
                end
                if (!hold_request) begin
                    state_nxt = ST_RELEASE;
                    rel_nxt   = '0;
                end else if (WDOG_EN && (dma_cnt == DMA_LAST)) begin
                    state_nxt = ST_RELEASE;
                    rel_nxt   = '0;
                    wd_nxt    = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (rel_cnt == REL_LAST) begin
                    state_nxt = ST_CPU;
                    fair_nxt  = FAIR_INIT;
                end else begin
                    rel_nxt = rel_cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_CPU;
            end
        endcase
    end

    // Outputs are registered decodes of the next state, so they switch on the transition edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_acknowledge <= 1'b0;
            address_enable_n <= 1'b1;
            cpu_bus_enable   <= 1'b1;
            cpu_wait_request <= 1'b0;
            watchdog_timeout <= 1'b0;
        end else begin
            hold_acknowledge <= (state_nxt == ST_DMA);
            address_enable_n <= cpu_owns_nxt;
            cpu_bus_enable   <= cpu_owns_nxt;
            cpu_wait_request <= !cpu_owns_nxt;
            watchdog_timeout <= wd_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed scenarios followed by random traffic on two differently
// parameterised arbiters, each compared every clock against a behavioural ownership model.
module tb_bus_arbiter;

    localparam int PH_CPU  = 0;
    localparam int PH_SYNC = 1;
    localparam int PH_AEN  = 2;
    localparam int PH_DMA  = 3;
    localparam int PH_REL  = 4;

    // Instance A: defaults with a short watchdog. Instance B: fast setup, long release,
    // no fairness gap, watchdog disabled.
    localparam int A_SETUP = 2, A_REL = 1, A_MIN = 4, A_MAX = 8;
    localparam int B_SETUP = 1, B_REL = 2, B_MIN = 0, B_MAX = 0;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [2:0] status;
    logic       lock_n;
    logic       hold;

    logic a_hlda, a_aen_n, a_cbe, a_wait, a_wd;
    logic b_hlda, b_aen_n, b_cbe, b_wait, b_wd;
    logic [4:0] obs_a, obs_b;

    assign obs_a = {a_hlda, a_aen_n, a_cbe, a_wait, a_wd};
    assign obs_b = {b_hlda, b_aen_n, b_cbe, b_wait, b_wd};

    int checks   = 0;
    int failures = 0;

    int   m_phase [2];
    int   m_left  [2];
    int   m_dma   [2];
    logic m_wd    [2];
    logic [2:0] m_prev;

    always #5 clock = ~clock;

    bus_arbiter #(
        .HOLD_SETUP_CYCLES(A_SETUP), .RELEASE_CYCLES(A_REL),
        .MIN_CPU_CYCLES(A_MIN), .MAX_DMA_CYCLES(A_MAX)
    ) dut_a (
        .clock(clock), .reset_n(reset_n), .processor_status(status),
        .processor_lock_n(lock_n), .hold_request(hold),
        .hold_acknowledge(a_hlda), .address_enable_n(a_aen_n),
        .cpu_bus_enable(a_cbe), .cpu_wait_request(a_wait), .watchdog_timeout(a_wd)
    );

    bus_arbiter #(
        .HOLD_SETUP_CYCLES(B_SETUP), .RELEASE_CYCLES(B_REL),
        .MIN_CPU_CYCLES(B_MIN), .MAX_DMA_CYCLES(B_MAX)
    ) dut_b (
        .clock(clock), .reset_n(reset_n), .processor_status(status),
        .processor_lock_n(lock_n), .hold_request(hold),
        .hold_acknowledge(b_hlda), .address_enable_n(b_aen_n),
        .cpu_bus_enable(b_cbe), .cpu_wait_request(b_wait), .watchdog_timeout(b_wd)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_phase[i] = PH_CPU;
            m_left[i]  = 0;
            m_dma[i]   = 0;
            m_wd[i]    = 1'b0;
        end
        m_prev = 3'b111;
    endtask

    // One clock of bus ownership for arbiter i, from the inputs sampled at that edge.
    task automatic model_edge(input int i, input int setup, input int rel,
                              input int min_cpu, input int max_dma);
        logic passive;
        logic go;
        passive  = (status == 3'b111) && (m_prev == 3'b111) && lock_n;
        m_wd[i]  = 1'b0;
        case (m_phase[i])
            PH_CPU: begin
                go = hold && (m_left[i] == 0);
                if (m_left[i] > 0) m_left[i] = m_left[i] - 1;
                if (go) m_phase[i] = PH_SYNC;
            end
            PH_SYNC: begin
                if (!hold) m_phase[i] = PH_CPU;
                else if (passive) begin
                    m_phase[i] = PH_AEN;
                    m_left[i]  = setup;
                end
            end
            PH_AEN: begin
                if (!hold) begin
                    m_phase[i] = PH_REL;
                    m_left[i]  = rel;
                end else begin
                    m_left[i] = m_left[i] - 1;
                    if (m_left[i] == 0) begin
                        m_phase[i] = PH_DMA;
                        m_dma[i]   = 0;
                    end
                end
            end
            PH_DMA: begin
                if (!hold) begin
                    m_phase[i] = PH_REL;
                    m_left[i]  = rel;
                end else begin
                    m_dma[i] = m_dma[i] + 1;
                    if (max_dma != 0 && m_dma[i] == max_dma) begin
                        m_wd[i]    = 1'b1;
                        m_phase[i] = PH_REL;
                        m_left[i]  = rel;
                    end
                end
            end
            default: begin
                m_left[i] = m_left[i] - 1;
                if (m_left[i] == 0) begin
                    m_phase[i] = PH_CPU;
                    m_left[i]  = min_cpu;
                end
            end
        endcase
    endtask

    // Expected {hlda, aen_n, cpu_bus_enable, cpu_wait_request, watchdog_timeout}.
    function automatic logic [4:0] exp_bits(input int i);
        logic dma_owned;
        dma_owned = (m_phase[i] == PH_AEN) || (m_phase[i] == PH_DMA) || (m_phase[i] == PH_REL);
        return {(m_phase[i] == PH_DMA), !dma_owned, !dma_owned, dma_owned, m_wd[i]};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        if (!reset_n) model_reset();
        else begin
            model_edge(0, A_SETUP, A_REL, A_MIN, A_MAX);
            model_edge(1, B_SETUP, B_REL, B_MIN, B_MAX);
            m_prev = status;
        end
        check("a_cycle", 8'(obs_a), 8'(exp_bits(0)));
        check("b_cycle", 8'(obs_b), 8'(exp_bits(1)));
    endtask

    task automatic idle(input int n);
        hold = 1'b0;
        status = 3'b111;
        lock_n = 1'b1;
        repeat (n) step();
    endtask

    // Asynchronous reset between edges must clear the outputs without waiting for a clock.
    task automatic async_reset_check();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check("rst_async_a", 8'(obs_a), 8'b01100);
        check("rst_async_b", 8'(obs_b), 8'b01100);
        step();
        reset_n = 1'b1;
    endtask

    initial begin
        int wd_cnt;
        int wd_edge;
        int early_grant;
        logic aen_e17;
        logic aen_e18;

        reset_n = 1'b0;
        hold    = 1'b0;
        status  = 3'b111;
        lock_n  = 1'b1;
        model_reset();
        repeat (2) step();
        check("rst_a", 8'(obs_a), 8'b01100);
        reset_n = 1'b1;
        idle(4);

        // Idle passive bus, 10-clock request.
        hold = 1'b1;
        step();
        check("t1_aen_e0", 8'(a_aen_n), 8'd1);
        step();
        check("t1_aen_e1", 8'(a_aen_n), 8'd0);
        check("t1_hlda_e1", 8'(a_hlda), 8'd0);
        step();
        check("t1_hlda_e2", 8'(a_hlda), 8'd0);
        step();
        check("t1_hlda_e3", 8'(a_hlda), 8'd1);
        repeat (6) step();
        hold = 1'b0;
        step();
        check("t1_hlda_e10", 8'(a_hlda), 8'd0);
        check("t1_aen_e10", 8'(a_aen_n), 8'd0);
        step();
        check("t1_aen_e11", 8'(a_aen_n), 8'd1);
        idle(8);

        // Active status holds the request in SYNC.
        hold   = 1'b1;
        status = 3'b001;
        repeat (4) step();
        check("t2_aen_busy", 8'(a_aen_n), 8'd1);
        status = 3'b111;
        step();
        check("t2_aen_first_passive", 8'(a_aen_n), 8'd1);
        step();
        check("t2_aen_grant_a", 8'(a_aen_n), 8'd0);
        check("t2_aen_grant_b", 8'(b_aen_n), 8'd0);
        idle(8);

        // LOCK# blocks the grant until released.
        lock_n = 1'b0;
        hold   = 1'b1;
        repeat (6) step();
        check("t3_aen_locked", 8'(a_aen_n), 8'd1);
        lock_n = 1'b1;
        step();
        check("t3_aen_unlocked", 8'(a_aen_n), 8'd0);
        idle(8);

        // Request withdrawn during address setup.
        hold = 1'b1;
        repeat (2) step();
        hold = 1'b0;
        step();
        check("t4_hlda_abort", 8'(a_hlda), 8'd0);
        check("t4_aen_release", 8'(a_aen_n), 8'd0);
        step();
        check("t4_restore", 8'({a_aen_n, a_cbe, a_wait}), 8'b110);
        idle(8);

        // Stuck request: watchdog, fairness gap, regrant.
        wd_cnt = 0;
        wd_edge = -1;
        early_grant = 0;
        aen_e17 = 1'b0;
        aen_e18 = 1'b1;
        hold = 1'b1;
        for (int k = 0; k <= 18; k++) begin
            step();
            if (a_wd) begin
                wd_cnt++;
                wd_edge = k;
            end
            if (k >= 12 && k <= 17 && !a_aen_n) early_grant++;
            if (k == 17) aen_e17 = a_aen_n;
            if (k == 18) aen_e18 = a_aen_n;
        end
        check("t5_wd_count", 8'(wd_cnt), 8'd1);
        check("t5_wd_edge", 8'(wd_edge), 8'd11);
        check("t5_no_early_grant", 8'(early_grant), 8'd0);
        check("t5_aen_e17", 8'(aen_e17), 8'd1);
        check("t5_regrant_e18", 8'(aen_e18), 8'd0);
        check("t5_b_still_dma", 8'({b_hlda, b_wd}), 8'b10);
        idle(8);

        // Reset in the middle of a DMA grant.
        hold = 1'b1;
        repeat (5) step();
        check("t6_in_dma", 8'(a_hlda), 8'd1);
        async_reset_check();
        idle(6);

        // Random traffic against the model, with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 9) == 0) hold = ~hold;
            status = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b111;
            lock_n = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 599) == 0) async_reset_check();
            else step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
